instruction_fetch_unit: RTL

//  Fetch stage feeding the instruction decoder. Owns the fetch PC and issues word requests to instruction

---
 rtl/instruction_fetch_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding word
// request at a time to instruction memory, buffers returned words with their
// PCs in a small FIFO and hands them to the decoder over valid/ready.
// A redirect flushes the buffer and restarts fetch at the new target; a
// request already in flight at that moment is drained and its data dropped.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic          imem_req_q;
  logic [31:0]   imem_addr_q;

  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic          push;
  logic          pop;
  logic          space_idle;
  logic          space_after;
  logic [31:0]   redirect_pc;
  logic [31:0]   fetch_pc_inc;

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst_out   = fifo_data_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];

  // Handshake decode and FIFO occupancy look-ahead used by the request FSM.
  always_comb begin
    pop          = (count_q != '0) && inst_ready;
    push         = (state_q == S_REQ) && imem_ack && !redirect_valid;
    count_d      = count_q + CW'(push) - CW'(pop);
    space_idle   = (count_q - CW'(pop)) < DEPTH_C;
    space_after  = count_d < DEPTH_C;
    redirect_pc  = redirect_target & ~32'h0000_0003;
    fetch_pc_inc = fetch_pc_q + 32'd4;
  end

  // Request FSM: fetch PC, registered imem_req/imem_addr, drain of stale requests.
  // A redirect never drops a pending request; it parks in DROP with the old
  // address held until the ack arrives, while fetch_pc already points at the target.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc;
      unique case (state_q)
        S_REQ: begin
          if (imem_ack) begin
            state_q     <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= redirect_pc;
          end else begin
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state_q     <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= redirect_pc;
          end
        end
        default: begin
          state_q     <= S_REQ;
          imem_req_q  <= 1'b1;
          imem_addr_q <= redirect_pc;
        end
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (space_idle) begin
            state_q     <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc_q;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            fetch_pc_q  <= fetch_pc_inc;
            imem_addr_q <= fetch_pc_inc;
            if (space_after) begin
              state_q    <= S_REQ;
              imem_req_q <= 1'b1;
            end else begin
              state_q    <= S_IDLE;
              imem_req_q <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state_q     <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc_q;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Instruction buffer: push acked words, pop on handshake, flush on redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
        fifo_data_q[wr_ptr_q] <= imem_rdata;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule
